// File: rtl/intersection_model.sv
// Two-direction intersection traffic model: vehicle queues drained on green with a
// minimum departure spacing, plus sticky checks on the controller's light codes.
module intersection_model #(
    parameter int QMAX = 15,
    parameter int GAP  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arr_a,
    input  logic       arr_b,
    input  logic [1:0] La,
    input  logic [1:0] Lb,
    input  logic       clr,
    output logic       Ta,
    output logic       Tb,
    output logic [3:0] qa,
    output logic [3:0] qb,
    output logic       dep_a,
    output logic       dep_b,
    output logic       ovf_a,
    output logic       ovf_b,
    output logic       conflict,
    output logic       seq_err,
    output logic       code_err
);

    typedef enum logic [1:0] {
        L_GREEN   = 2'd0,
        L_YELLOW  = 2'd1,
        L_RED     = 2'd2,
        L_INVALID = 2'd3
    } light_e;

    localparam logic [3:0] QMAX_C   = 4'(QMAX);
    localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

    logic [1:0] arr_w;
    logic [1:0] light_w [2];
    logic [3:0] cnt_w   [2];
    logic [1:0] dep_w;
    logic [1:0] ovf_w;
    logic [1:0] seq_evt_w;

    assign arr_w      = {arr_b, arr_a};
    assign light_w[0] = La;
    assign light_w[1] = Lb;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dir
            light_e     code;
            light_e     trk_q, trk_d;
            logic [3:0] cnt_q, cnt_d;
            logic [3:0] gap_q, gap_d;
            logic       dep_q, dep_d;
            logic       ovf_q, ovf_d;
            logic       depart;
            logic       ovf_set;
            logic       legal;

            assign code = light_e'(light_w[gi]);

            always_comb begin
                depart  = (code == L_GREEN) && (cnt_q != 4'd0) && (gap_q == 4'd0);
                cnt_d   = cnt_q;
                ovf_set = 1'b0;
                gap_d   = gap_q;
                legal   = 1'b1;
                trk_d   = trk_q;

                if (arr_w[gi] && !depart) begin
                    if (cnt_q == QMAX_C) begin
                        ovf_set = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (!arr_w[gi] && depart) begin
                    cnt_d = cnt_q - 4'd1;
                end

                // Leaving green clears the spacing so the next green departs at once.
                if (code != L_GREEN) begin
                    gap_d = 4'd0;
                end else if (depart) begin
                    gap_d = GAP_LOAD;
                end else if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end

                case (trk_q)
                    L_GREEN:  legal = (code == L_GREEN)  || (code == L_YELLOW);
                    L_YELLOW: legal = (code == L_YELLOW) || (code == L_RED);
                    L_RED:    legal = (code == L_RED)    || (code == L_GREEN);
                    default:  legal = 1'b1;
                endcase

                // An invalid code is neither judged nor remembered.
                if (code != L_INVALID) begin
                    trk_d = code;
                end

                dep_d = depart;
                ovf_d = clr ? 1'b0 : (ovf_q | ovf_set);
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= 4'd0;
                    gap_q <= 4'd0;
                    dep_q <= 1'b0;
                    ovf_q <= 1'b0;
                    trk_q <= L_RED;
                end else begin
                    cnt_q <= cnt_d;
                    gap_q <= gap_d;
                    dep_q <= dep_d;
                    ovf_q <= ovf_d;
                    trk_q <= trk_d;
                end
            end

            assign cnt_w[gi]     = cnt_q;
            assign dep_w[gi]     = dep_q;
            assign ovf_w[gi]     = ovf_q;
            assign seq_evt_w[gi] = (code != L_INVALID) && !legal;
        end
    endgenerate

    logic conflict_q, conflict_d;
    logic seq_err_q, seq_err_d;
    logic code_err_q, code_err_d;
    logic conflict_evt;
    logic code_evt;

    always_comb begin
        conflict_evt = !La[1] && !Lb[1];
        code_evt     = (La == 2'd3) || (Lb == 2'd3);
        conflict_d   = clr ? 1'b0 : (conflict_q | conflict_evt);
        seq_err_d    = clr ? 1'b0 : (seq_err_q | (|seq_evt_w));
        code_err_d   = clr ? 1'b0 : (code_err_q | code_evt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_q <= 1'b0;
            seq_err_q  <= 1'b0;
            code_err_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
            seq_err_q  <= seq_err_d;
            code_err_q <= code_err_d;
        end
    end

    assign qa       = cnt_w[0];
    assign qb       = cnt_w[1];
    assign Ta       = (cnt_w[0] != 4'd0);
    assign Tb       = (cnt_w[1] != 4'd0);
    assign dep_a    = dep_w[0];
    assign dep_b    = dep_w[1];
    assign ovf_a    = ovf_w[0];
    assign ovf_b    = ovf_w[1];
    assign conflict = conflict_q;
    assign seq_err  = seq_err_q;
    assign code_err = code_err_q;

endmodule

// File: tb/tb_intersection_model.sv
// Scoreboard bench for intersection_model: each driven cycle pushes the reference
// model's post-edge outputs; a monitor pops and compares one record per clock edge.
module tb_intersection_model;

    localparam int QMAX = 15;
    localparam int GAP  = 2;

    logic       clk;
    logic       rst;
    logic       arr_a, arr_b;
    logic [1:0] La, Lb;
    logic       clr;
    logic       Ta, Tb;
    logic [3:0] qa, qb;
    logic       dep_a, dep_b, ovf_a, ovf_b, conflict, seq_err, code_err;

    intersection_model #(.QMAX(QMAX), .GAP(GAP)) dut (
        .clk      (clk),
        .rst      (rst),
        .arr_a    (arr_a),
        .arr_b    (arr_b),
        .La       (La),
        .Lb       (Lb),
        .clr      (clr),
        .Ta       (Ta),
        .Tb       (Tb),
        .qa       (qa),
        .qb       (qb),
        .dep_a    (dep_a),
        .dep_b    (dep_b),
        .ovf_a    (ovf_a),
        .ovf_b    (ovf_b),
        .conflict (conflict),
        .seq_err  (seq_err),
        .code_err (code_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int edge_no   = 0;

    logic [16:0] exp_q [$];

    // Reference state of the intersection, kept as plain integers.
    int m_cnt  [2];
    int m_gap  [2];
    int m_prev [2];
    bit m_dep  [2];
    bit m_ovf  [2];
    bit m_conf, m_seq, m_code;

    function automatic logic [16:0] model_vec();
        return {m_cnt[0] != 0, m_cnt[1] != 0, 4'(m_cnt[0]), 4'(m_cnt[1]),
                m_dep[0], m_dep[1], m_ovf[0], m_ovf[1], m_conf, m_seq, m_code};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {Ta, Tb, qa, qb, dep_a, dep_b, ovf_a, ovf_b, conflict, seq_err, code_err};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]  = 0;
            m_gap[d]  = 0;
            m_prev[d] = 2;
            m_dep[d]  = 0;
            m_ovf[d]  = 0;
        end
        m_conf = 0;
        m_seq  = 0;
        m_code = 0;
    endtask

    task automatic model_step(input bit a0, input bit a1, input int l0, input int l1,
                              input bit c, input bit r);
        bit arr [2];
        int lt  [2];
        bit seq_ev, code_ev, conf_ev, dep, ov;
        int n;
        if (!r) begin
            model_reset();
            return;
        end
        arr[0] = a0; arr[1] = a1;
        lt[0]  = l0; lt[1]  = l1;
        seq_ev  = 0;
        code_ev = 0;
        for (int d = 0; d < 2; d++) begin
            dep = (lt[d] == 0) && (m_cnt[d] > 0) && (m_gap[d] == 0);
            n   = m_cnt[d] + int'(arr[d]) - int'(dep);
            ov  = 0;
            if (n > QMAX) begin
                n  = QMAX;
                ov = 1;
            end
            m_cnt[d] = n;
            m_dep[d] = dep;
            if (lt[d] != 0)      m_gap[d] = 0;
            else if (dep)        m_gap[d] = GAP - 1;
            else if (m_gap[d] > 0) m_gap[d] = m_gap[d] - 1;
            if (lt[d] == 3) begin
                code_ev = 1;
            end else begin
                if (lt[d] != m_prev[d] && lt[d] != (m_prev[d] + 1) % 3) seq_ev = 1;
                m_prev[d] = lt[d];
            end
            m_ovf[d] = c ? 1'b0 : (m_ovf[d] | ov);
        end
        conf_ev = (lt[0] <= 1) && (lt[1] <= 1);
        m_conf  = c ? 1'b0 : (m_conf | conf_ev);
        m_seq   = c ? 1'b0 : (m_seq  | seq_ev);
        m_code  = c ? 1'b0 : (m_code | code_ev);
    endtask

    // Called at a falling edge: drive one cycle, record its expected outcome, advance.
    task automatic cyc(input bit a0, input bit a1, input int l0, input int l1, input bit c);
        arr_a = a0;
        arr_b = a1;
        La    = 2'(l0);
        Lb    = 2'(l1);
        clr   = c;
        model_step(a0, a1, l0, l1, c, rst);
        exp_q.push_back(model_vec());
        @(negedge clk);
    endtask

    task automatic expect_now(input string name, input int act, input int req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, req);
    endtask

    task automatic drop_reset();
        rst = 1'b0;
        #1;
        expect_now("reset_immediate", int'(dut_vec()), 0);
    endtask

    // Monitor: one scoreboard record per rising edge, sampled just after it.
    initial begin
        logic [16:0] e;
        logic [16:0] a;
        forever begin
            @(posedge clk);
            #1;
            edge_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = dut_vec();
                total_cnt++;
                if (a === e) pass_cnt++;
                else $display("FAIL scoreboard edge=%0d actual=%05h required=%05h", edge_no, a, e);
            end
        end
    end

    int la_v, lb_v;

    function automatic int next_light(input int cur);
        int r;
        r = int'($urandom_range(99));
        if (r < 70)      return cur;
        else if (r < 90) return (cur == 3) ? 2 : (cur + 1) % 3;
        else             return int'($urandom_range(3));
    endfunction

    initial begin
        rst   = 1'b0;
        arr_a = 1'b0;
        arr_b = 1'b0;
        La    = 2'd2;
        Lb    = 2'd2;
        clr   = 1'b0;
        model_reset();
        @(negedge clk);
        cyc(1, 1, 2, 2, 0);                       // arrivals during reset are dropped
        cyc(0, 0, 2, 2, 0);
        rst = 1'b1;

        // Three arrivals on red: queue builds, nothing departs.
        for (int i = 0; i < 3; i++) cyc(1, 0, 2, 2, 0);
        expect_now("qa_after_3_arrivals", int'(qa), 3);
        expect_now("Ta_after_arrivals", int'(Ta), 1);

        // Green drains with GAP spacing.
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 2, 0);
        expect_now("qa_drained", int'(qa), 0);
        expect_now("Ta_drained", int'(Ta), 0);
        cyc(0, 0, 1, 2, 0);
        cyc(0, 0, 2, 2, 0);

        // Saturation of queue b, then clear of the sticky overflow.
        for (int i = 0; i < 17; i++) cyc(0, 1, 2, 2, 0);
        expect_now("qb_saturated", int'(qb), QMAX);
        expect_now("ovf_b_set", int'(ovf_b), 1);
        cyc(0, 0, 2, 2, 1);
        expect_now("ovf_b_cleared", int'(ovf_b), 0);
        expect_now("qb_held", int'(qb), QMAX);

        // Conflict, illegal sequence, invalid code.
        for (int i = 0; i < 5; i++) cyc(1, 0, 2, 2, 0);
        cyc(0, 0, 0, 2, 0);
        cyc(0, 0, 0, 0, 0);
        expect_now("conflict_set", int'(conflict), 1);
        cyc(0, 0, 2, 1, 0);
        expect_now("seq_err_set", int'(seq_err), 1);
        cyc(0, 0, 3, 2, 0);
        expect_now("code_err_set", int'(code_err), 1);
        expect_now("dep_a_on_invalid", int'(dep_a), 0);
        cyc(0, 0, 2, 2, 1);
        expect_now("flags_cleared", int'({conflict, seq_err, code_err}), 0);

        // Drain a, load one vehicle, then arrival coinciding with departure.
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 2, 0);
        cyc(0, 0, 1, 2, 0);
        cyc(1, 0, 2, 2, 0);
        cyc(1, 0, 0, 2, 0);
        expect_now("qa_arr_and_dep", int'(qa), 1);
        expect_now("dep_a_arr_and_dep", int'(dep_a), 1);
        cyc(1, 0, 0, 2, 0);
        drop_reset();
        cyc(1, 1, 0, 0, 0);
        rst = 1'b1;
        la_v = 2;
        lb_v = 2;

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 800; i++) begin
            la_v = next_light(la_v);
            lb_v = next_light(lb_v);
            if ($urandom_range(199) == 0) begin
                drop_reset();
                cyc(1'($urandom), 1'($urandom), la_v, lb_v, 0);
                rst = 1'b1;
            end else begin
                cyc(1'($urandom_range(99) < 45), 1'($urandom_range(99) < 45),
                    la_v, lb_v, 1'($urandom_range(99) < 3));
            end
        end

        cyc(0, 0, 2, 2, 0);
        @(negedge clk);
        expect_now("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
